// File: rtl/s2mm_sts_monitor_pkg.sv
// Shared constants, state encoding and status decode for the S2MM status monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package s2mm_sts_pkg;

  // Status beat bit positions
  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  // Command word layout
  localparam int CMD_TAG_LSB = 64;
  localparam int CMD_W       = 72;
  localparam int STS_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // A beat is bad when OKAY is clear or any of the error flags is set.
  function automatic logic sts_is_err(input logic [STS_W-1:0] s);
    return !s[STS_OKAY] || s[STS_SLVERR] || s[STS_DECERR] || s[STS_INTERR];
  endfunction

endpackage

// File: rtl/s2mm_sts_monitor_if.sv
// Command snoop + status stream bundle between the datamover and the monitor.
// Latency: n/a (wires only).
// Backpressure: sts_tready flows monitor->datamover; the cmd pair is observe-only.
// Ports: cmd_tvalid/cmd_tready/cmd_tdata (snoop), sts_tvalid/sts_tready/sts_tdata.
interface s2mm_sts_monitor_if;
  import s2mm_sts_pkg::*;

  logic             cmd_tvalid;
  logic             cmd_tready;
  logic [CMD_W-1:0] cmd_tdata;
  logic             sts_tvalid;
  logic             sts_tready;
  logic [STS_W-1:0] sts_tdata;

  // master = datamover side, slave = monitor side
  modport master (
    output cmd_tvalid, cmd_tready, cmd_tdata, sts_tvalid, sts_tdata,
    input  sts_tready
  );

  modport slave (
    input  cmd_tvalid, cmd_tready, cmd_tdata, sts_tvalid, sts_tdata,
    output sts_tready
  );

endinterface

// File: rtl/s2mm_sts_monitor_tag_fifo.sv
// Outstanding-tag FIFO: holds issued command tags until their status returns.
// Latency: head/count reflect a push or pop on the next cycle; head is combinational off storage.
// Backpressure: none; a push while full is dropped unless a pop frees a slot that cycle.
// Ports: clk, rstb, push/din, pop, flush (sync clear), head, full, empty, count.
module tag_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/s2mm_sts_monitor.sv
// S2MM status monitor: tracks issued tags, checks returning status, counts completions.
// Latency: every counter/flag updates one cycle after the command or status handshake.
// Backpressure: none; sts_tready is tied high in all states.
// Ports: axis_st_clk/axis_st_rstb, bus (slave), write_start/write_reset/cap_size,
//        cmds_done, bytes_done, outstanding, last_status, err_sticky, err_code,
//        tag_err, cap_done, done_irq, busy.
module s2mm_sts_monitor
  import s2mm_sts_pkg::*;
#(
  parameter int BTT_BYTES = 4096,
  parameter int TAG_W     = 4,
  parameter int MAX_OUT   = 16
) (
  input  logic                        axis_st_clk,
  input  logic                        axis_st_rstb,
  s2mm_sts_monitor_if.slave           bus,
  input  logic                        write_start,
  input  logic                        write_reset,
  input  logic [31:0]                 cap_size,
  output logic [31:0]                 cmds_done,
  output logic [31:0]                 bytes_done,
  output logic [$clog2(MAX_OUT):0]    outstanding,
  output logic [7:0]                  last_status,
  output logic                        err_sticky,
  output logic [3:0]                  err_code,
  output logic                        tag_err,
  output logic                        cap_done,
  output logic                        done_irq,
  output logic                        busy
);
  localparam int LOG_BTT = $clog2(BTT_BYTES);

  state_t            state_q, state_nxt;
  logic              hs_cmd, hs_sts, beat_err, arm;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [TAG_W-1:0]  fifo_head;
  logic              tag_fault;
  logic [31:0]       num_cmds;
  logic [32:0]       num_calc;
  logic [32+LOG_BTT-1:0] bytes_wide;
  logic              unused;

  assign bus.sts_tready = 1'b1;

  assign hs_cmd   = bus.cmd_tvalid && bus.cmd_tready;
  assign hs_sts   = bus.sts_tvalid && bus.sts_tready;
  assign beat_err = sts_is_err(bus.sts_tdata);
  // Arming is only honoured outside an active or failed capture.
  assign arm      = write_start && (state_q == IDLE || state_q == DONE);
  assign num_calc = ({1'b0, cap_size} + 33'(BTT_BYTES - 1)) >> LOG_BTT;

  // Underflow beats pop nothing; a same-cycle push cannot satisfy them.
  assign fifo_pop  = hs_sts && !fifo_empty;
  assign tag_fault = (hs_sts && fifo_empty)
                  || (fifo_pop && (fifo_head != bus.sts_tdata[TAG_W-1:0]))
                  || (hs_cmd && fifo_full && !fifo_pop);

  assign bytes_wide = (32+LOG_BTT)'(cmds_done) << LOG_BTT;
  assign bytes_done = (|bytes_wide[32+LOG_BTT-1:32]) ? 32'hFFFF_FFFF : bytes_wide[31:0];

  assign unused = ^{bus.cmd_tdata[CMD_W-1:CMD_TAG_LSB+TAG_W],
                    bus.cmd_tdata[CMD_TAG_LSB-1:0], num_calc[32]};

  tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk   (axis_st_clk),
    .rstb  (axis_st_rstb),
    .push  (hs_cmd),
    .din   (bus.cmd_tdata[CMD_TAG_LSB +: TAG_W]),
    .pop   (fifo_pop),
    .flush (write_reset),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // FSM: state register
  always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
    if (!axis_st_rstb) state_q <= IDLE;
    else               state_q <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, DONE: if (write_start) state_nxt = (cap_size == '0) ? DONE : RUN;
      RUN: if (hs_sts) begin
        if (beat_err)                          state_nxt = ERROR;
        else if (cmds_done + 32'd1 == num_cmds) state_nxt = DONE;
      end
      default: state_nxt = state_q;
    endcase
    if (write_reset) state_nxt = IDLE;
  end

  // FSM: outputs
  always_comb begin
    busy     = 1'b0;
    cap_done = 1'b0;
    case (state_q)
      RUN:     busy     = 1'b1;
      DONE:    cap_done = 1'b1;
      default: ;
    endcase
  end

  // Counters and sticky flags
  always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
    if (!axis_st_rstb) begin
      cmds_done   <= '0;
      num_cmds    <= '0;
      last_status <= '0;
      err_sticky  <= 1'b0;
      err_code    <= '0;
      tag_err     <= 1'b0;
      done_irq    <= 1'b0;
    end else if (write_reset) begin
      cmds_done   <= '0;
      num_cmds    <= '0;
      last_status <= '0;
      err_sticky  <= 1'b0;
      err_code    <= '0;
      tag_err     <= 1'b0;
      done_irq    <= 1'b0;
    end else begin
      done_irq <= (state_nxt == DONE) && (state_q != DONE);
      if (hs_sts) last_status <= bus.sts_tdata;
      if (arm) begin
        // Clears win over a beat landing in the arming cycle.
        cmds_done  <= '0;
        num_cmds   <= num_calc[31:0];
        err_sticky <= 1'b0;
        err_code   <= '0;
        tag_err    <= 1'b0;
      end else begin
        if (hs_sts) begin
          cmds_done <= cmds_done + 32'd1;
          if (beat_err && !err_sticky) begin
            err_sticky <= 1'b1;
            err_code   <= bus.sts_tdata[STS_OKAY:STS_INTERR];
          end
        end
        if (tag_fault) tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s2mm_sts_monitor.sv
// Directed self-checking bench for s2mm_sts_monitor.
// Latency: outputs sampled 1ns after the edge that captured each handshake.
// Backpressure: sts_tready is expected high throughout.
module tb_s2mm_sts_monitor;

  logic        clk = 1'b0;
  logic        rstb;
  logic        write_start;
  logic        write_reset;
  logic [31:0] cap_size;
  logic [31:0] cmds_done, bytes_done;
  logic [4:0]  outstanding;
  logic [7:0]  last_status;
  logic        err_sticky, tag_err, cap_done, done_irq, busy;
  logic [3:0]  err_code;

  int n_cmp = 0;
  int n_err = 0;

  s2mm_sts_monitor_if bus ();

  s2mm_sts_monitor #(.BTT_BYTES(4096), .TAG_W(4), .MAX_OUT(16)) dut (
    .axis_st_clk  (clk),
    .axis_st_rstb (rstb),
    .bus          (bus),
    .write_start  (write_start),
    .write_reset  (write_reset),
    .cap_size     (cap_size),
    .cmds_done    (cmds_done),
    .bytes_done   (bytes_done),
    .outstanding  (outstanding),
    .last_status  (last_status),
    .err_sticky   (err_sticky),
    .err_code     (err_code),
    .tag_err      (tag_err),
    .cap_done     (cap_done),
    .done_irq     (done_irq),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] tag);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_tready = 1'b1;
    bus.cmd_tdata  = {4'hA, tag, 64'h1234_5678_0000_1000};
    tick();
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tready = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] s);
    bus.sts_tvalid = 1'b1;
    bus.sts_tdata  = s;
    tick();
    bus.sts_tvalid = 1'b0;
  endtask

  task automatic arm(input logic [31:0] sz);
    cap_size    = sz;
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
  endtask

  task automatic wreset();
    write_reset = 1'b1;
    tick();
    write_reset = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    write_start = 1'b0;
    write_reset = 1'b0;
    cap_size = '0;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tready = 1'b0;
    bus.cmd_tdata  = '0;
    bus.sts_tvalid = 1'b0;
    bus.sts_tdata  = '0;
    tick(); tick();
    rstb = 1'b1;
    tick();

    // Reset state
    check("rst_cmds",   cmds_done, 0);
    check("rst_bytes",  bytes_done, 0);
    check("rst_out",    outstanding, 0);
    check("rst_tready", bus.sts_tready, 1);
    check("rst_flags",  {busy, cap_done, done_irq, err_sticky, tag_err}, 0);
    check("rst_last",   {last_status, err_code}, 0);

    // 1: four clean commands
    arm(32'd16384);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) send_cmd(4'(i));
    check("t1_out4", outstanding, 4);
    for (int i = 0; i < 3; i++) send_sts(8'h80 + 8'(i));
    check("t1_notdone", cap_done, 0);
    send_sts(8'h83);
    check("t1_cmds",  cmds_done, 4);
    check("t1_bytes", bytes_done, 16384);
    check("t1_done",  cap_done, 1);
    check("t1_irq",   done_irq, 1);
    check("t1_tag",   tag_err, 0);
    check("t1_last",  last_status, 8'h83);
    tick();
    check("t1_irq_off", done_irq, 0);
    check("t1_hold",    cap_done, 1);

    // cmd_tvalid without cmd_tready is not a handshake
    bus.cmd_tvalid = 1'b1; bus.cmd_tready = 1'b0;
    tick();
    bus.cmd_tvalid = 1'b0;
    check("t1_no_hs", outstanding, 0);

    // 2: re-arm from DONE, 5000 bytes -> 2 commands
    arm(32'd5000);
    check("t2_rearm", {busy, cap_done, 32'(cmds_done)}, {2'b10, 32'd0});
    send_cmd(4'd0); send_cmd(4'd1);
    send_sts(8'h80);
    check("t2_first", {cap_done, done_irq}, 2'b00);
    check("t2_bytes1", bytes_done, 4096);
    send_sts(8'h81);
    check("t2_second", {cap_done, done_irq}, 2'b11);
    check("t2_bytes2", bytes_done, 8192);
    wreset();
    check("t2_wreset", {cap_done, busy, 32'(cmds_done)}, 0);
    arm(32'd0);
    check("t2_zero", {cap_done, done_irq, busy}, 3'b110);
    tick();
    check("t2_zero_irq", {cap_done, done_irq}, 2'b10);

    // 3: SLVERR -> ERROR, first error code sticks
    wreset();
    arm(32'd4096);
    send_cmd(4'd0);
    send_sts(8'hC0);
    check("t3_err",   {err_sticky, err_code}, 5'h1C);
    check("t3_state", {busy, cap_done, done_irq}, 0);
    send_sts(8'h00);
    check("t3_code",  err_code, 4'hC);
    check("t3_cmds",  cmds_done, 2);
    check("t3_uflow", tag_err, 1);
    arm(32'd4096);
    check("t3_absorb", {busy, err_sticky}, 2'b01);

    // 4: tag mismatch, underflow, simultaneous push/pop
    wreset();
    arm(32'd65536);
    send_cmd(4'd2);
    check("t4_out1", outstanding, 1);
    send_sts(8'h85);
    check("t4_mis", {tag_err, err_sticky}, 2'b10);
    check("t4_out0", outstanding, 0);
    wreset();
    arm(32'd65536);
    send_sts(8'h80);
    check("t4_uflow", {tag_err, 5'(outstanding)}, 6'b100000);
    wreset();
    arm(32'd65536);
    send_cmd(4'd1);
    bus.cmd_tvalid = 1'b1; bus.cmd_tready = 1'b1;
    bus.cmd_tdata  = {4'h0, 4'd3, 64'h0};
    bus.sts_tvalid = 1'b1; bus.sts_tdata = 8'h81;
    tick();
    bus.cmd_tvalid = 1'b0; bus.cmd_tready = 1'b0; bus.sts_tvalid = 1'b0;
    check("t4_pushpop", {tag_err, 5'(outstanding)}, 6'b000001);
    send_sts(8'h83);
    check("t4_drain", {tag_err, 5'(outstanding)}, 6'b000000);
    wreset();
    bus.cmd_tvalid = 1'b1; bus.cmd_tready = 1'b1;
    bus.cmd_tdata  = {4'h0, 4'd5, 64'h0};
    bus.sts_tvalid = 1'b1; bus.sts_tdata = 8'h85;
    tick();
    bus.cmd_tvalid = 1'b0; bus.cmd_tready = 1'b0; bus.sts_tvalid = 1'b0;
    check("t4_uflow_push", {tag_err, 5'(outstanding)}, 6'b100001);

    // 5: overflow on the 17th command
    wreset();
    for (int i = 0; i < 16; i++) send_cmd(4'(i));
    check("t5_full", {tag_err, 5'(outstanding)}, {1'b0, 5'd16});
    send_cmd(4'd0);
    check("t5_ovf", {tag_err, 5'(outstanding)}, {1'b1, 5'd16});

    // 6: write_reset mid-capture
    wreset();
    arm(32'd16384);
    for (int i = 0; i < 4; i++) send_cmd(4'(i));
    send_sts(8'h80); send_sts(8'h81);
    check("t6_mid", cmds_done, 2);
    wreset();
    check("t6_cleared", {busy, cap_done, tag_err, 5'(outstanding), 32'(cmds_done)}, 0);
    check("t6_bytes", bytes_done, 0);
    send_sts(8'h82);
    check("t6_late", {tag_err, cap_done, done_irq}, 3'b100);
    check("t6_cmds", cmds_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
